s_acq_capture: RTL and testbench
================================

Name: s_acq_capture

Overview:
- Sample-capture receiver for the NMR acquisition path. It consumes the gated divide-by-4 ADC sample clock produced from clk_dds and samples the ADC data bus on each sample-clock rising edge.
- It averages groups of 2^ACC_SHIFT samples and delivers a programmed number of averaged echo points downstream over a valid/ready handshake.
- It runs entirely in the clk_dds domain. The sample clock arrives as a registered same-domain signal, so no CDC logic is required.

Parameters:
- DATA_W, 12, ADC sample width and output word width.
- CNT_W, 16, width of the point counter and of num_samples.
- ACC_SHIFT, 2, log2 of the number of samples averaged per output word (0 means no averaging).

Ports:
- clk_dds  in  1  DDS system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- entop  in  1  top-level acquisition enable.
- s_acq_en  in  1  acquisition window enable; en = entop & s_acq_en.
- adc_clk  in  1  divided ADC sample clock. It is 0 while en is 0 and toggles every 2 clk_dds cycles otherwise.
- adc_data  in  DATA_W  ADC output bus, valid on the clk_dds cycle in which the adc_clk rising edge is detected.
- num_samples  in  CNT_W  number of output words per acquisition; latched at start.
- out_data  out  DATA_W  averaged sample.
- out_valid  out  1  out_data holds a word not yet accepted.
- out_ready  in  1  downstream accept.
- sample_cnt  out  CNT_W  words loaded into the output register in the current acquisition.
- busy  out  1  acquisition in progress (state is not IDLE).
- done  out  1  one-cycle pulse on normal completion.
- overrun  out  1  sticky flag: an averaged word was dropped due to backpressure.

Behaviour:
- Reset: state IDLE. out_data, out_valid, sample_cnt, busy, done, overrun, the accumulator, the group counter and adc_clk_d are all 0.
- en_d is a registered copy of en. Start condition: en & ~en_d while in IDLE.
- States:
  - IDLE. On start: latch num_samples into n_lat, clear sample_cnt, overrun, accumulator and group counter, then go to ARM.
  - ARM. If n_lat == 0, go to FINISH. Otherwise wait for adc_clk == 0, then go to CAPTURE.
  - CAPTURE. Strobe when adc_clk_d == 0 and adc_clk == 1; adc_data is captured on that same cycle.
    - Accumulator width is DATA_W+ACC_SHIFT, unsigned add.
    - On the 2^ACC_SHIFT-th strobe of a group, the result is (acc + adc_data) >> ACC_SHIFT (truncating). The accumulator restarts at 0 for the next group, so no strobe is lost.
  - FINISH. Wait until out_valid == 0. Then pulse done for 1 cycle and go to IDLE.
- Latency: result strobe at cycle t gives out_valid = 1 and out_data loaded at t+1. With the divide-by-4 clock and ACC_SHIFT = 2, one word is produced every 16 clk_dds cycles.
- Output handshake:
  - A transfer occurs when out_valid & out_ready. out_valid is cleared after the transfer unless a new result loads on the same cycle.
  - New result while out_valid = 0, or while out_valid = 1 and out_ready = 1: load out_data, out_valid = 1, sample_cnt increments.
  - New result while out_valid = 1 and out_ready = 0: the result is dropped, out_data is unchanged, overrun is set, and sample_cnt does not increment.
- Completion: when sample_cnt becomes n_lat, go to FINISH. Further strobes are ignored.
- Abort: en = 0 in ARM or CAPTURE goes to IDLE on the next cycle.
  - The partial group is discarded.
  - A pending out_valid word remains and is still deliverable.
  - No done pulse; sample_cnt and overrun hold.
- en = 0 in FINISH does not abort.
- Re-arm requires a new en rising edge. Holding en high after done does not restart.
- busy = 1 in ARM, CAPTURE and FINISH.
- Full scale: all samples 2^DATA_W-1 average to 2^DATA_W-1 with no wrap.
- Asserting rst mid-acquisition returns to the reset values immediately.

Test Plan:
- Reset asserted mid-CAPTURE -> all outputs 0 asynchronously and state IDLE; no done after release.
- Basic run:
  - Stimulus: ACC_SHIFT = 2, num_samples = 3, adc_data = 0x100 constant, out_ready = 1.
  - Required: three out_valid pulses 16 cycles apart with out_data = 0x100, sample_cnt = 3, exactly one done pulse, busy falls with done.
  - Repeat with adc_data = 0xFFF: out_data = 0xFFF.
- Truncation: group samples 1, 2, 2, 2 -> out_data = 0x001 (sum 7 >> 2).
- Backpressure:
  - Stimulus: out_ready = 0 for 40 cycles, num_samples = 4.
  - Required: first word held unchanged, second word dropped, overrun = 1, sample_cnt = 1. Once out_ready returns to 1, acquisition continues to sample_cnt = 4 and then done.
- Abort: s_acq_en dropped after 6 strobes -> IDLE next cycle, busy = 0, no done. A new en rise restarts with sample_cnt = 0 and overrun = 0.
- num_samples = 0 -> done pulse within 3 cycles of the en rise, out_valid never asserted.

Source files
------------

// File: rtl/s_acq_capture_if.sv
// Output stream bundle of the acquisition capture block: averaged word plus
// its valid/ready handshake. The capture block is the master.
interface s_acq_capture_if #(
  parameter int DATA_W = 12
) ();

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface : s_acq_capture_if

// File: rtl/s_acq_capture.sv
// NMR acquisition sample-capture receiver.
// Samples adc_data on each rising edge of the divided ADC clock (detected in
// the clk_dds domain), averages groups of 2^ACC_SHIFT samples and delivers
// num_samples averaged words over a valid/ready handshake. A word that
// arrives while the previous one is still stalled is dropped and flagged in
// the sticky overrun bit.
module s_acq_capture #(
  parameter int DATA_W    = 12,
  parameter int CNT_W     = 16,
  parameter int ACC_SHIFT = 2
) (
  input  logic                 clk_dds,
  input  logic                 rst,
  input  logic                 entop,
  input  logic                 s_acq_en,
  input  logic                 adc_clk,
  input  logic [DATA_W-1:0]    adc_data,
  input  logic [CNT_W-1:0]     num_samples,
  s_acq_capture_if.master      out_if,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  // Accumulator holds a full group sum without wrap; the group counter needs
  // at least one bit even when averaging is disabled.
  localparam int ACC_W = DATA_W + ACC_SHIFT;
  localparam int GRP_W = (ACC_SHIFT > 0) ? ACC_SHIFT : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              done_set;

  logic              en;
  logic              en_d;
  logic              adc_clk_d;
  logic              start;
  logic              strobe;
  logic              grp_last;
  logic              res_strobe;
  logic              load;
  logic              drop;

  logic [CNT_W-1:0]  n_lat;
  logic [CNT_W-1:0]  cnt_inc;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [GRP_W-1:0]  grp_cnt;
  logic [DATA_W-1:0] result;

  // ---------------------------------------------------------------------------
  // Datapath decode
  // ---------------------------------------------------------------------------
  assign en      = entop & s_acq_en;
  assign start   = (state == IDLE) & en & ~en_d;

  // A sample is taken on the clk_dds cycle where the registered copy of the
  // ADC clock is still low but the live one is high. Qualifying with en keeps
  // an abort cycle from ever being counted as a sample.
  assign strobe  = (state == CAPTURE) & en & ~adc_clk_d & adc_clk;

  assign acc_sum = acc + ACC_W'(adc_data);
  assign result  = DATA_W'(acc_sum >> ACC_SHIFT);

  // Last sample of a group: counter saturated, or every sample when there is
  // no averaging.
  assign grp_last   = (ACC_SHIFT == 0) ? 1'b1 : (&grp_cnt);
  assign res_strobe = strobe & grp_last;

  // A finished average loads if the output register is empty or is being
  // emptied this very cycle; otherwise it is lost.
  assign load    = res_strobe & (~out_if.out_valid | out_if.out_ready);
  assign drop    = res_strobe & out_if.out_valid & ~out_if.out_ready;
  assign cnt_inc = sample_cnt + CNT_W'(1);

  assign busy    = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_dds or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and the done request.
  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (n_lat == '0) begin
          state_nxt = FINISH;
        end else if (!adc_clk) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (load && (cnt_inc == n_lat)) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        // Completion waits for the last word to drain; dropping en here is
        // deliberately not an abort.
        if (!out_if.out_valid) begin
          done_set  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Edge detectors and acquisition length latch
  // ---------------------------------------------------------------------------

  // Delayed copies of en and the ADC clock for edge detection; length latched
  // at start so the count cannot change mid-acquisition.
  always_ff @(posedge clk_dds or posedge rst) begin
    if (rst) begin
      en_d      <= 1'b0;
      adc_clk_d <= 1'b0;
      n_lat     <= '0;
    end else begin
      en_d      <= en;
      adc_clk_d <= adc_clk;
      if (start) begin
        n_lat <= num_samples;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Averaging
  // ---------------------------------------------------------------------------

  // Group accumulation; the last sample of a group is folded into result
  // combinationally so the accumulator restarts cleanly at zero.
  always_ff @(posedge clk_dds or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      grp_cnt <= '0;
    end else if (start) begin
      acc     <= '0;
      grp_cnt <= '0;
    end else if (strobe) begin
      if (grp_last) begin
        acc     <= '0;
        grp_cnt <= '0;
      end else begin
        acc     <= acc_sum;
        grp_cnt <= grp_cnt + GRP_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register, handshake and status
  // ---------------------------------------------------------------------------

  // Output word/valid: load wins over the clearing transfer on the same cycle.
  always_ff @(posedge clk_dds or posedge rst) begin
    if (rst) begin
      out_if.out_data  <= '0;
      out_if.out_valid <= 1'b0;
    end else if (load) begin
      out_if.out_data  <= result;
      out_if.out_valid <= 1'b1;
    end else if (out_if.out_valid && out_if.out_ready) begin
      out_if.out_valid <= 1'b0;
    end
  end

  // Word count, sticky overrun and the registered done pulse. A pending word
  // from an aborted run survives a restart; only the counters are cleared.
  always_ff @(posedge clk_dds or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      overrun    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= done_set;
      if (start) begin
        sample_cnt <= '0;
        overrun    <= 1'b0;
      end else begin
        if (load) begin
          sample_cnt <= cnt_inc;
        end
        if (drop) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule : s_acq_capture

// File: tb/tb_s_acq_capture.sv
// Self-checking bench for s_acq_capture: a table of complete acquisitions
// plus hand-written sequences for backpressure, abort, late en drop and
// asynchronous reset.
module tb_s_acq_capture;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 16;

  logic              clk_dds  = 1'b0;
  logic              rst      = 1'b0;
  logic              entop    = 1'b0;
  logic              s_acq_en = 1'b0;
  logic              adc_clk;
  logic [DATA_W-1:0] adc_data;
  logic [CNT_W-1:0]  num_samples = '0;
  logic [CNT_W-1:0]  sample_cnt;
  logic              busy;
  logic              done;
  logic              overrun;

  s_acq_capture_if #(.DATA_W(DATA_W)) bus ();

  s_acq_capture #(
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .ACC_SHIFT(2)
  ) dut (
    .clk_dds    (clk_dds),
    .rst        (rst),
    .entop      (entop),
    .s_acq_en   (s_acq_en),
    .adc_clk    (adc_clk),
    .adc_data   (adc_data),
    .num_samples(num_samples),
    .out_if     (bus),
    .sample_cnt (sample_cnt),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clk_dds = ~clk_dds;

  // ADC model: divide-by-4 clock held low while disabled; sample k of the
  // acquisition is presented on the cycle of its rising edge.
  logic              adc_en;
  logic [1:0]        ph   = 2'd0;
  logic [4:0]        sidx = 5'd0;
  logic [DATA_W-1:0] pat [32];

  assign adc_en   = entop & s_acq_en;
  assign adc_clk  = adc_en & ph[1];
  assign adc_data = pat[sidx];

  always @(posedge clk_dds) begin
    if (!adc_en) begin
      ph   <= 2'd0;
      sidx <= 5'd0;
    end else begin
      ph <= ph + 2'd1;
      if (ph == 2'd2) sidx <= sidx + 5'd1;
    end
  end

  int cyc = 0;
  always @(posedge clk_dds) cyc <= cyc + 1;

  // Monitor: record transfers, done pulses and valid cycles mid-cycle.
  int xfer_data[$];
  int xfer_cyc[$];
  int done_cyc[$];
  int done_busy[$];
  int valid_cnt = 0;

  always @(negedge clk_dds) begin
    if (bus.out_valid) valid_cnt <= valid_cnt + 1;
    if (bus.out_valid && bus.out_ready) begin
      xfer_data.push_back(int'(bus.out_data));
      xfer_cyc.push_back(cyc);
    end
    if (done) begin
      done_cyc.push_back(cyc);
      done_busy.push_back(int'(busy));
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_dds);
    #1;
  endtask

  task automatic wait_done(input int budget, output int ok);
    int d0;
    d0 = done_cyc.size();
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (done_cyc.size() > d0) begin
        ok = 1;
        break;
      end
    end
  endtask

  typedef struct {
    int          num;
    logic [11:0] d0, d1, d2, d3;
    int          exp_data;
    int          exp_done;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int ok, xs, ds, vs, t0;

    // Hand-computed acquisitions: done cycle = 17 + 16*(num-1), or 3 for num=0.
    vecs[0] = '{num: 3, d0: 12'h100, d1: 12'h100, d2: 12'h100, d3: 12'h100, exp_data: 'h100, exp_done: 49};
    vecs[1] = '{num: 3, d0: 12'hFFF, d1: 12'hFFF, d2: 12'hFFF, d3: 12'hFFF, exp_data: 'hFFF, exp_done: 49};
    vecs[2] = '{num: 1, d0: 12'h001, d1: 12'h002, d2: 12'h002, d3: 12'h002, exp_data: 'h001, exp_done: 17};
    vecs[3] = '{num: 2, d0: 12'hFFF, d1: 12'hFFF, d2: 12'hFFF, d3: 12'hFFE, exp_data: 'hFFE, exp_done: 33};
    vecs[4] = '{num: 0, d0: 12'h123, d1: 12'h123, d2: 12'h123, d3: 12'h123, exp_data: 0,     exp_done: 3};

    for (int i = 0; i < 32; i++) pat[i] = '0;
    bus.out_ready = 1'b1;

    // Reset values.
    #1 rst = 1'b1;
    tick(3);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_sample_cnt", int'(sample_cnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    tick(2);
    entop = 1'b1;

    // Table of complete acquisitions with out_ready held high.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 32; i++) begin
        case (i % 4)
          0:       pat[i] = vecs[v].d0;
          1:       pat[i] = vecs[v].d1;
          2:       pat[i] = vecs[v].d2;
          default: pat[i] = vecs[v].d3;
        endcase
      end
      num_samples   = CNT_W'(vecs[v].num);
      bus.out_ready = 1'b1;
      xs = xfer_data.size();
      ds = done_cyc.size();
      vs = valid_cnt;
      s_acq_en = 1'b1;
      t0 = cyc;
      wait_done(400, ok);
      check($sformatf("v%0d_done_seen", v), ok, 1);
      tick(30);  // en still high: must not restart
      check($sformatf("v%0d_sample_cnt", v), int'(sample_cnt), vecs[v].num);
      check($sformatf("v%0d_overrun", v), int'(overrun), 0);
      check($sformatf("v%0d_busy_after", v), int'(busy), 0);
      s_acq_en = 1'b0;
      tick(4);
      check($sformatf("v%0d_n_xfer", v), xfer_data.size() - xs, vecs[v].num);
      check($sformatf("v%0d_n_done", v), done_cyc.size() - ds, 1);
      check($sformatf("v%0d_done_cyc", v), done_cyc[ds] - t0, vecs[v].exp_done);
      check($sformatf("v%0d_busy_at_done", v), done_busy[ds], 0);
      check($sformatf("v%0d_valid_cycles", v), valid_cnt - vs, vecs[v].num);
      for (int k = 0; k < vecs[v].num; k++) begin
        check($sformatf("v%0d_word%0d", v, k), xfer_data[xs + k], vecs[v].exp_data);
        if (k == 0)
          check($sformatf("v%0d_first_lat", v), xfer_cyc[xs] - t0, 15);
        else
          check($sformatf("v%0d_spacing%0d", v, k), xfer_cyc[xs + k] - xfer_cyc[xs + k - 1], 16);
      end
    end

    // Backpressure: group averages 0x10,0x20,... ; ready low for 40 cycles.
    for (int i = 0; i < 32; i++) pat[i] = DATA_W'(((i / 4) + 1) * 16);
    num_samples   = 16'd4;
    bus.out_ready = 1'b0;
    xs = xfer_data.size();
    ds = done_cyc.size();
    s_acq_en = 1'b1;
    t0 = cyc;
    tick(35);
    check("bp_valid_held", int'(bus.out_valid), 1);
    check("bp_data_held", int'(bus.out_data), 'h10);
    check("bp_overrun", int'(overrun), 1);
    check("bp_sample_cnt", int'(sample_cnt), 1);
    tick(5);
    bus.out_ready = 1'b1;
    wait_done(200, ok);
    check("bp_done_seen", ok, 1);
    check("bp_sample_cnt_end", int'(sample_cnt), 4);
    check("bp_overrun_sticky", int'(overrun), 1);
    check("bp_n_xfer", xfer_data.size() - xs, 4);
    check("bp_word0", xfer_data[xs], 'h10);
    check("bp_word1", xfer_data[xs + 1], 'h30);
    check("bp_word2", xfer_data[xs + 2], 'h40);
    check("bp_word3", xfer_data[xs + 3], 'h50);
    check("bp_n_done", done_cyc.size() - ds, 1);
    s_acq_en = 1'b0;
    tick(4);

    // Abort after 6 strobes with a word pending (ready low).
    for (int i = 0; i < 32; i++) pat[i] = 12'h050;
    num_samples   = 16'd10;
    bus.out_ready = 1'b0;
    ds = done_cyc.size();
    s_acq_en = 1'b1;
    tick(1);
    check("ab_start_cnt", int'(sample_cnt), 0);
    check("ab_start_overrun", int'(overrun), 0);
    check("ab_start_busy", int'(busy), 1);
    tick(22);  // cycle 23: strobes at 2,6,...,22 are done
    s_acq_en = 1'b0;
    tick(1);
    check("ab_busy", int'(busy), 0);
    check("ab_pending_valid", int'(bus.out_valid), 1);
    check("ab_pending_data", int'(bus.out_data), 'h50);
    check("ab_sample_cnt", int'(sample_cnt), 1);
    tick(20);
    check("ab_no_done", done_cyc.size() - ds, 0);
    bus.out_ready = 1'b1;
    tick(1);
    check("ab_drained", int'(bus.out_valid), 0);
    check("ab_drained_word", xfer_data[xfer_data.size() - 1], 'h50);

    // Restart after abort: the partial group must not leak into the average.
    for (int i = 0; i < 32; i++) pat[i] = 12'h020;
    num_samples = 16'd1;
    xs = xfer_data.size();
    s_acq_en = 1'b1;
    tick(1);
    check("rs_start_cnt", int'(sample_cnt), 0);
    wait_done(100, ok);
    check("rs_done_seen", ok, 1);
    check("rs_word", xfer_data[xs], 'h20);
    check("rs_sample_cnt", int'(sample_cnt), 1);
    s_acq_en = 1'b0;
    tick(4);

    // en dropped while in FINISH is not an abort.
    for (int i = 0; i < 32; i++) pat[i] = 12'h033;
    num_samples   = 16'd1;
    bus.out_ready = 1'b0;
    ds = done_cyc.size();
    s_acq_en = 1'b1;
    tick(20);
    s_acq_en = 1'b0;
    tick(5);
    check("fin_busy", int'(busy), 1);
    check("fin_no_done_yet", done_cyc.size() - ds, 0);
    bus.out_ready = 1'b1;
    wait_done(20, ok);
    check("fin_done_seen", ok, 1);
    check("fin_word", xfer_data[xfer_data.size() - 1], 'h33);
    tick(4);

    // Asynchronous reset in the middle of CAPTURE with a word pending.
    for (int i = 0; i < 32; i++) pat[i] = 12'h077;
    num_samples   = 16'd5;
    bus.out_ready = 1'b0;
    s_acq_en = 1'b1;
    tick(20);
    check("ar_pre_valid", int'(bus.out_valid), 1);
    #2;
    rst      = 1'b1;
    s_acq_en = 1'b0;
    #1;
    check("ar_out_valid", int'(bus.out_valid), 0);
    check("ar_out_data", int'(bus.out_data), 0);
    check("ar_sample_cnt", int'(sample_cnt), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_overrun", int'(overrun), 0);
    check("ar_done", int'(done), 0);
    ds = done_cyc.size();
    tick(2);
    rst = 1'b0;
    tick(40);
    check("ar_no_done", done_cyc.size() - ds, 0);
    check("ar_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_s_acq_capture
